// File: rtl/iic_cmd_sequencer.sv
// Command sequencer ahead of the IIC master driver: walks an external init table
// of register writes, then periodically reads a two-byte sensor value.
module iic_cmd_sequencer #(
    parameter int          INIT_LEN    = 8,
    parameter int          POWERUP_CYC = 20000,
    parameter int          GAP_CYC     = 200,
    parameter int          POLL_CYC    = 5000000,
    parameter int          TIMEOUT_CYC = 100000,
    parameter logic [7:0]  RD_SLAVE    = 8'h88,
    parameter logic [7:0]  RD_REG      = 8'h00,
    localparam int         IDX_W       = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             restart,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [23:0]      tbl_data,
    output logic [15:0]      iic_slave,
    output logic             iic_write_req,
    output logic [7:0]       iic_write_data,
    input  logic             iic_write_done,
    output logic             iic_read_req,
    input  logic             iic_read_done,
    input  logic [7:0]       iic_read_data,
    output logic             init_done,
    output logic [15:0]      sensor_data,
    output logic             data_valid,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT_REQ, S_INIT_WAIT, S_GAP, S_POLL_IDLE, S_RD_REQ, S_RD_WAIT
    } state_t;

    localparam logic [31:0] PWR_LAST  = (POWERUP_CYC > 0) ? 32'(POWERUP_CYC - 1) : 32'd0;
    localparam logic [31:0] GAP_LAST  = (GAP_CYC > 0) ? 32'(GAP_CYC - 1) : 32'd0;
    localparam logic [31:0] POLL_LAST = (POLL_CYC > 0) ? 32'(POLL_CYC - 1) : 32'd0;
    localparam logic [31:0] TO_LIM    = 32'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((INIT_LEN > 0) ? INIT_LEN - 1 : 0);
    localparam logic        NO_INIT   = (INIT_LEN == 0);
    localparam state_t      FIRST_ST  = NO_INIT ? S_POLL_IDLE : S_INIT_REQ;

    state_t      state, gap_next;
    logic [31:0] cnt;
    logic        sel, rst_pend;
    logic [7:0]  shadow_hi;

    logic in_wait, wr_exit, rd_exit, wait_exit, restart_now;
    assign in_wait     = (state == S_INIT_WAIT) || (state == S_RD_WAIT);
    assign wr_exit     = (state == S_INIT_WAIT) && (iic_write_done || cnt == TO_LIM);
    assign rd_exit     = (state == S_RD_WAIT) && (iic_read_done || cnt == TO_LIM);
    assign wait_exit   = wr_exit || rd_exit;
    assign restart_now = restart && !in_wait;

    // Requests are registered out of the *_REQ state, so the pulse, iic_slave and
    // iic_write_data all become visible together on the following cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_PWRUP;
            gap_next       <= S_POLL_IDLE;
            cnt            <= '0;
            sel            <= 1'b0;
            rst_pend       <= 1'b0;
            shadow_hi      <= '0;
            tbl_idx        <= '0;
            iic_slave      <= '0;
            iic_write_req  <= 1'b0;
            iic_write_data <= '0;
            iic_read_req   <= 1'b0;
            init_done      <= 1'b0;
            sensor_data    <= '0;
            data_valid     <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
        end else begin
            iic_write_req <= 1'b0;
            iic_read_req  <= 1'b0;
            data_valid    <= 1'b0;
            cnt           <= cnt + 32'd1;

            case (state)
                S_PWRUP: if (cnt == PWR_LAST) begin
                    cnt   <= '0;
                    state <= FIRST_ST;
                    if (NO_INIT) init_done <= 1'b1;
                end
                S_INIT_REQ: begin
                    iic_write_req  <= 1'b1;
                    iic_slave      <= {tbl_data[15:8], tbl_data[23:16]};
                    iic_write_data <= tbl_data[7:0];
                    busy           <= 1'b1;
                    cnt            <= '0;
                    state          <= S_INIT_WAIT;
                end
                S_INIT_WAIT: if (wr_exit) begin
                    if (!iic_write_done) err <= 1'b1;
                    busy     <= 1'b0;
                    tbl_idx  <= tbl_idx + IDX_W'(1);
                    cnt      <= '0;
                    state    <= S_GAP;
                    gap_next <= (tbl_idx == LAST_IDX) ? S_POLL_IDLE : S_INIT_REQ;
                end
                S_GAP: if (cnt == GAP_LAST) begin
                    cnt   <= '0;
                    state <= gap_next;
                    if (gap_next == S_POLL_IDLE) init_done <= 1'b1;
                end
                S_POLL_IDLE: if (cnt == POLL_LAST) begin
                    cnt   <= '0;
                    sel   <= 1'b0;
                    state <= S_RD_REQ;
                end
                S_RD_REQ: begin
                    iic_read_req <= 1'b1;
                    iic_slave    <= {RD_REG + {7'd0, sel}, RD_SLAVE};
                    busy         <= 1'b1;
                    cnt          <= '0;
                    state        <= S_RD_WAIT;
                end
                S_RD_WAIT: if (rd_exit) begin
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= S_GAP;
                    if (iic_read_done) begin
                        if (!sel) begin
                            shadow_hi <= iic_read_data;
                            sel       <= 1'b1;
                            gap_next  <= S_RD_REQ;
                        end else begin
                            sensor_data <= {shadow_hi, iic_read_data};
                            data_valid  <= 1'b1;
                            gap_next    <= S_POLL_IDLE;
                        end
                    end else begin
                        err      <= 1'b1;
                        gap_next <= S_POLL_IDLE;
                    end
                end
                default: state <= S_PWRUP;
            endcase

            // A restart seen while a driver transaction is in flight waits for its
            // done/timeout, then still honours the gap before re-running init.
            if (wait_exit && (rst_pend || restart)) begin
                tbl_idx   <= '0;
                init_done <= 1'b0;
                err       <= 1'b0;
                sel       <= 1'b0;
                rst_pend  <= 1'b0;
                gap_next  <= FIRST_ST;
            end else if (in_wait && restart) begin
                rst_pend <= 1'b1;
            end

            if (restart_now) begin
                tbl_idx       <= '0;
                init_done     <= NO_INIT;
                err           <= 1'b0;
                sel           <= 1'b0;
                rst_pend      <= 1'b0;
                iic_write_req <= 1'b0;
                iic_read_req  <= 1'b0;
                busy          <= 1'b0;
                cnt           <= '0;
                state         <= FIRST_ST;
            end
        end
    end

endmodule

// File: tb/tb_iic_cmd_sequencer.sv
// Directed bench: the main process plays the IIC driver, acking requests by hand.
module tb_iic_cmd_sequencer;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic [1:0]  tbl_idx;
    logic [23:0] tbl_data;
    logic [15:0] iic_slave;
    logic        iic_write_req, iic_read_req;
    logic [7:0]  iic_write_data;
    logic        iic_write_done = 1'b0, iic_read_done = 1'b0;
    logic [7:0]  iic_read_data = 8'h00;
    logic        init_done, data_valid, busy, err;
    logic [15:0] sensor_data;

    int n_cmp = 0, n_bad = 0;
    int dv_cnt = 0;
    bit proto_bad = 1'b0, prev_req = 1'b0;
    int lat;

    logic [23:0] tbl [0:3];
    assign tbl_data = tbl[tbl_idx];

    always #5 sys_clk = ~sys_clk;

    iic_cmd_sequencer #(
        .INIT_LEN(3), .POWERUP_CYC(10), .GAP_CYC(4), .POLL_CYC(1000),
        .TIMEOUT_CYC(500), .RD_SLAVE(8'h88), .RD_REG(8'h00)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .restart(restart),
        .tbl_idx(tbl_idx), .tbl_data(tbl_data), .iic_slave(iic_slave),
        .iic_write_req(iic_write_req), .iic_write_data(iic_write_data),
        .iic_write_done(iic_write_done), .iic_read_req(iic_read_req),
        .iic_read_done(iic_read_done), .iic_read_data(iic_read_data),
        .init_done(init_done), .sensor_data(sensor_data), .data_valid(data_valid),
        .busy(busy), .err(err)
    );

    // Request protocol watch: never both at once, never back-to-back.
    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (iic_write_req && iic_read_req) proto_bad = 1'b1;
            if ((iic_write_req || iic_read_req) && prev_req) proto_bad = 1'b1;
            prev_req = iic_write_req || iic_read_req;
            if (data_valid) dv_cnt++;
        end else begin
            prev_req = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input int budget, output int l);
        l = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge sys_clk);
            if (iic_write_req || iic_read_req) begin
                l = i;
                break;
            end
        end
    endtask

    // Driver pulses both dones together; done lands dly cycles after the request.
    task automatic ack(input int dly, input logic [7:0] rdata);
        repeat (dly - 1) @(negedge sys_clk);
        iic_write_done = 1'b1;
        iic_read_done  = 1'b1;
        iic_read_data  = rdata;
        @(negedge sys_clk);
        iic_write_done = 1'b0;
        iic_read_done  = 1'b0;
    endtask

    function automatic logic [63:0] outs();
        return {16'd0, tbl_idx, iic_slave, iic_write_req, iic_write_data, iic_read_req,
                init_done, sensor_data, data_valid, busy, err};
    endfunction

    initial begin
        tbl[0] = 24'h7800AE;
        tbl[1] = 24'h788D14;
        tbl[2] = 24'h78AF00;
        tbl[3] = 24'h000000;

        repeat (3) @(negedge sys_clk);
        chk("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;

        // Init table, every write acked after 30 cycles
        wait_req(50, lat);
        chk("pwrup_latency", 64'(lat), 64'd11);
        chk("w0_is_write", {63'd0, iic_write_req}, 64'd1);
        chk("w0_slave", 64'(iic_slave), 64'h0078);
        chk("w0_data", 64'(iic_write_data), 64'hAE);
        chk("w0_busy", {63'd0, busy}, 64'd1);
        ack(30, 8'h00);
        wait_req(50, lat);
        chk("gap_latency", 64'(lat), 64'd5);
        chk("w1_slave", 64'(iic_slave), 64'h8D78);
        chk("w1_data", 64'(iic_write_data), 64'h14);
        ack(30, 8'h00);
        wait_req(50, lat);
        chk("w2_slave", 64'(iic_slave), 64'hAF78);
        chk("w2_data", 64'(iic_write_data), 64'h00);
        ack(30, 8'h00);
        repeat (3) @(negedge sys_clk);
        chk("init_done_in_gap", {63'd0, init_done}, 64'd0);
        @(negedge sys_clk);
        chk("init_done_after_gap", {63'd0, init_done}, 64'd1);
        chk("init_err", {63'd0, err}, 64'd0);

        // First poll burst: 0x12, 0x34
        wait_req(1100, lat);
        chk("poll_latency", 64'(lat), 64'd1001);
        chk("r0_is_read", {63'd0, iic_read_req}, 64'd1);
        chk("r0_slave", 64'(iic_slave), 64'h0088);
        ack(30, 8'h12);
        wait_req(50, lat);
        chk("r1_latency", 64'(lat), 64'd5);
        chk("r1_slave", 64'(iic_slave), 64'h0188);
        ack(30, 8'h34);
        chk("dv_pulse", {63'd0, data_valid}, 64'd1);
        chk("sensor_1234", 64'(sensor_data), 64'h1234);
        @(negedge sys_clk);
        chk("dv_single_cycle", {63'd0, data_valid}, 64'd0);

        // Second burst: sel 1 never acked
        wait_req(1100, lat);
        chk("repoll_latency", 64'(lat), 64'd1004);
        ack(30, 8'h56);
        wait_req(50, lat);
        chk("r1b_slave", 64'(iic_slave), 64'h0188);
        repeat (500) @(negedge sys_clk);
        chk("rd_err_before_to", {63'd0, err}, 64'd0);
        chk("rd_busy_before_to", {63'd0, busy}, 64'd1);
        @(negedge sys_clk);
        chk("rd_err_at_to", {63'd0, err}, 64'd1);
        chk("rd_busy_after_to", {63'd0, busy}, 64'd0);
        wait_req(1100, lat);
        chk("poll_after_to", 64'(lat), 64'd1005);
        chk("sensor_held", 64'(sensor_data), 64'h1234);
        chk("dv_count_to", 64'(dv_cnt), 64'd1);

        // Third burst: restart during read wait
        chk("r0c_slave", 64'(iic_slave), 64'h0088);
        repeat (4) @(negedge sys_clk);
        restart = 1'b1;
        @(negedge sys_clk);
        restart = 1'b0;
        wait_req(20, lat);
        chk("no_req_while_wait", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("err_kept_in_wait", {63'd0, err}, 64'd1);
        ack(5, 8'h77);
        chk("restart_err_clr", {63'd0, err}, 64'd0);
        chk("restart_init_clr", {63'd0, init_done}, 64'd0);
        chk("restart_idx", 64'(tbl_idx), 64'd0);
        wait_req(50, lat);
        chk("restart_latency", 64'(lat), 64'd5);
        chk("rs_w0_is_write", {63'd0, iic_write_req}, 64'd1);
        chk("rs_w0_slave", 64'(iic_slave), 64'h0078);

        // Rerun of init: entry 1 never acked
        ack(30, 8'h00);
        wait_req(50, lat);
        chk("rs_w1_slave", 64'(iic_slave), 64'h8D78);
        repeat (500) @(negedge sys_clk);
        chk("wr_err_before_to", {63'd0, err}, 64'd0);
        @(negedge sys_clk);
        chk("wr_err_at_to", {63'd0, err}, 64'd1);
        wait_req(50, lat);
        chk("w2_after_to_lat", 64'(lat), 64'd5);
        chk("rs_w2_slave", 64'(iic_slave), 64'hAF78);
        chk("rs_w2_data", 64'(iic_write_data), 64'h00);
        ack(30, 8'h00);
        repeat (4) @(negedge sys_clk);
        chk("rs_init_done", {63'd0, init_done}, 64'd1);
        chk("rs_err_sticky", {63'd0, err}, 64'd1);

        // Restart from poll idle takes effect at once
        restart = 1'b1;
        @(negedge sys_clk);
        restart = 1'b0;
        wait_req(10, lat);
        chk("idle_restart_lat", 64'(lat), 64'd1);
        chk("idle_restart_err", {63'd0, err}, 64'd0);

        // Async reset mid init wait
        repeat (10) @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", outs(), 64'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        wait_req(50, lat);
        chk("post_reset_latency", 64'(lat), 64'd11);
        chk("post_reset_slave", 64'(iic_slave), 64'h0078);

        chk("req_protocol", {63'd0, proto_bad}, 64'd0);
        chk("dv_count_final", 64'(dv_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
